parity_check_fifo: RTL and testbench

PARITY_CHECK_FIFO -- requirements
Module: parity_check_fifo

---
 rtl/parity_check_fifo.sv | 122 ++++++++++++
 tb/tb_parity_check_fifo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/parity_check_fifo.sv
// Parity-checking capture FIFO: a debounced capture FSM samples {DIN,PIN} from a
// tristate upstream stage, flags parity errors per word, and pops on READ.
module parity_check_fifo #(
  parameter int DEPTH      = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WRITE,
  input  logic       READ,
  input  logic [0:7] DIN,
  input  logic       PIN,
  output logic [0:7] DOUT,
  output logic       POUT,
  output logic       PERR,
  output logic       VALID,
  output logic       FULL,
  output logic       EMPTY,
  output logic [0:7] ERRCNT,
  output logic       OVF
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  state_t           state, state_nxt;
  logic             bus_act, bus_prev, bus_rise;
  logic             do_cap, do_push, do_pop, err_bit;
  logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic             full_nxt, empty_nxt;
  logic [7:0]       data_mem [DEPTH];
  logic [DEPTH-1:0] par_mem;
  logic [DEPTH-1:0] err_mem;

  function automatic logic parity_err(input logic [7:0] d, input logic p);
    return (^d) ^ p ^ (PARITY_ODD != 0);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign bus_act = WRITE & ~READ;
  assign bus_rise = bus_act & ~bus_prev;

  // Tracks the bus through reset too, so a strobe held across reset release
  // is not mistaken for a fresh bus-active edge.
  always_ff @(posedge CLK) begin
    bus_prev <= bus_act;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus_rise) state_nxt = SETTLE;
      SETTLE:  state_nxt = bus_act ? CAPTURE : IDLE;
      CAPTURE: state_nxt = HOLD;
      HOLD:    if (!bus_act) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign do_cap  = (state == CAPTURE);
  assign do_push = do_cap & ~FULL;
  assign do_pop  = READ & ~EMPTY;
  assign err_bit = parity_err(DIN, PIN);

  assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, do_push};
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_pop};
  assign full_nxt   = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                      (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
  assign empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);

  // Capture stage: FSM, pointers, flags, error bookkeeping
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      FULL    <= 1'b0;
      EMPTY   <= 1'b1;
      ERRCNT  <= '0;
      OVF     <= 1'b0;
      err_mem <= '0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      FULL   <= full_nxt;
      EMPTY  <= empty_nxt;
      if (do_push) err_mem[wr_ptr[AW-1:0]] <= err_bit;
      if (do_cap && err_bit) ERRCNT <= sat_inc(ERRCNT);
      if (do_cap && FULL) OVF <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) begin
      data_mem[wr_ptr[AW-1:0]] <= DIN;
      par_mem[wr_ptr[AW-1:0]]  <= PIN;
    end
  end

  // Pop stage: head entry registered onto the output bus with a VALID pulse
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      VALID <= 1'b0;
      DOUT  <= '0;
      POUT  <= 1'b0;
      PERR  <= 1'b0;
    end else begin
      VALID <= do_pop;
      if (do_pop) begin
        DOUT <= data_mem[rd_ptr[AW-1:0]];
        POUT <= par_mem[rd_ptr[AW-1:0]];
        PERR <= err_mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_parity_check_fifo.sv
// Directed bench for parity_check_fifo: a per-cycle vector table for the basic
// capture/pop behaviour, plus sequences for overflow, async reset and wrap.
module tb_parity_check_fifo;

  logic       CLK = 1'b0;
  logic       RST, WRITE, READ, PIN;
  logic [0:7] DIN;

  logic [0:7] dout, errcnt, odd_dout, odd_errcnt;
  logic       pout, perr, valid, full, empty, ovf;
  logic       odd_pout, odd_perr, odd_valid, odd_full, odd_empty, odd_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  parity_check_fifo #(.DEPTH(4), .PARITY_ODD(0)) dut (
    .CLK(CLK), .RST(RST), .WRITE(WRITE), .READ(READ), .DIN(DIN), .PIN(PIN),
    .DOUT(dout), .POUT(pout), .PERR(perr), .VALID(valid), .FULL(full),
    .EMPTY(empty), .ERRCNT(errcnt), .OVF(ovf)
  );

  parity_check_fifo #(.DEPTH(4), .PARITY_ODD(1)) dut_odd (
    .CLK(CLK), .RST(RST), .WRITE(WRITE), .READ(READ), .DIN(DIN), .PIN(PIN),
    .DOUT(odd_dout), .POUT(odd_pout), .PERR(odd_perr), .VALID(odd_valid),
    .FULL(odd_full), .EMPTY(odd_empty), .ERRCNT(odd_errcnt), .OVF(odd_ovf)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] din;
    logic       pin;
    logic       valid;
    logic [7:0] dout;
    logic       perr;
    logic       perr_odd;
    logic       empty;
    logic [7:0] errcnt;
  } vec_t;

  localparam int NV = 31;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic w, input logic r, input logic [7:0] din,
                              input logic pin, input logic v, input logic [7:0] d,
                              input logic pe, input logic peo, input logic e,
                              input logic [7:0] ec);
    vec_t t;
    t.w = w; t.r = r; t.din = din; t.pin = pin; t.valid = v; t.dout = d;
    t.perr = pe; t.perr_odd = peo; t.empty = e; t.errcnt = ec;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic capture(input logic [7:0] d, input logic p);
    WRITE = 1'b1; READ = 1'b0; DIN = d; PIN = p;
    repeat (3) tick();
    WRITE = 1'b0;
    tick();
  endtask

  task automatic pop_chk(input string nm, input logic [7:0] d, input logic pe);
    READ = 1'b1;
    tick();
    READ = 1'b0;
    chk({nm, ".valid"}, valid, 1'b1);
    chk({nm, ".dout"}, dout, d);
    chk({nm, ".perr"}, perr, pe);
  endtask

  initial begin
    // cycle table: inputs before the edge, outputs just after it
    tbl[0]  = mk(1, 0, 8'hAA, 0, 0, 8'h00, 0, 0, 1, 0);
    tbl[1]  = mk(1, 0, 8'hAA, 0, 0, 8'h00, 0, 0, 1, 0);
    tbl[2]  = mk(1, 0, 8'hAA, 0, 0, 8'h00, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 8'hAA, 0, 1, 8'hAA, 0, 1, 1, 0);
    tbl[4]  = mk(0, 0, 8'hAA, 0, 0, 8'hAA, 0, 1, 1, 0);
    tbl[5]  = mk(1, 0, 8'hA2, 0, 0, 8'hAA, 0, 1, 1, 0);
    tbl[6]  = mk(1, 0, 8'hA2, 0, 0, 8'hAA, 0, 1, 1, 0);
    tbl[7]  = mk(1, 0, 8'hA2, 0, 0, 8'hAA, 0, 1, 0, 1);
    tbl[8]  = mk(0, 1, 8'hA2, 0, 1, 8'hA2, 1, 0, 1, 1);
    tbl[9]  = mk(0, 0, 8'hA2, 0, 0, 8'hA2, 1, 0, 1, 1);
    tbl[10] = mk(1, 0, 8'hA2, 1, 0, 8'hA2, 1, 0, 1, 1);
    tbl[11] = mk(1, 0, 8'hA2, 1, 0, 8'hA2, 1, 0, 1, 1);
    tbl[12] = mk(1, 0, 8'hA2, 1, 0, 8'hA2, 1, 0, 0, 1);
    tbl[13] = mk(0, 1, 8'hA2, 1, 1, 8'hA2, 0, 1, 1, 1);
    tbl[14] = mk(0, 0, 8'hA2, 1, 0, 8'hA2, 0, 1, 1, 1);
    tbl[15] = mk(1, 0, 8'h33, 0, 0, 8'hA2, 0, 1, 1, 1);
    tbl[16] = mk(0, 0, 8'h33, 0, 0, 8'hA2, 0, 1, 1, 1);
    tbl[17] = mk(0, 0, 8'h33, 0, 0, 8'hA2, 0, 1, 1, 1);
    tbl[18] = mk(0, 1, 8'h33, 0, 0, 8'hA2, 0, 1, 1, 1);
    for (int i = 19; i <= 28; i++)
      tbl[i] = mk(1, 0, 8'h5A, 0, 0, 8'hA2, 0, 1, (i < 21) ? 1'b1 : 1'b0, 1);
    tbl[29] = mk(0, 1, 8'h5A, 0, 1, 8'h5A, 0, 1, 1, 1);
    tbl[30] = mk(0, 0, 8'h5A, 0, 0, 8'h5A, 0, 1, 1, 1);

    RST = 1'b1; WRITE = 1'b0; READ = 1'b0; DIN = '0; PIN = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    tick();
    chk("rst.valid", valid, 1'b0);
    chk("rst.dout", dout, 8'h00);
    chk("rst.empty", empty, 1'b1);
    chk("rst.full", full, 1'b0);
    chk("rst.errcnt", errcnt, 8'h00);
    chk("rst.ovf", ovf, 1'b0);

    for (int i = 0; i < NV; i++) begin
      WRITE = tbl[i].w; READ = tbl[i].r; DIN = tbl[i].din; PIN = tbl[i].pin;
      tick();
      chk($sformatf("vec%0d {valid,dout,perr,perr_odd,empty,errcnt}", i),
          {valid, dout, perr, odd_perr, empty, errcnt},
          {tbl[i].valid, tbl[i].dout, tbl[i].perr, tbl[i].perr_odd, tbl[i].empty, tbl[i].errcnt});
    end
    WRITE = 1'b0; READ = 1'b0;
    tick();

    // fill to DEPTH, then one more capture overflows
    capture(8'h01, 1); capture(8'h02, 1); capture(8'h03, 0);
    chk("fill3.full", full, 1'b0);
    capture(8'h04, 1);
    chk("fill4.full", full, 1'b1);
    chk("fill4.ovf", ovf, 1'b0);
    capture(8'h05, 0);
    chk("fill5.ovf", ovf, 1'b1);
    chk("fill5.full", full, 1'b1);
    chk("fill5.errcnt", errcnt, 8'd1);
    pop_chk("ovf.pop1", 8'h01, 0);
    chk("ovf.full_after_pop", full, 1'b0);
    pop_chk("ovf.pop2", 8'h02, 0);
    pop_chk("ovf.pop3", 8'h03, 0);
    pop_chk("ovf.pop4", 8'h04, 0);
    chk("ovf.empty", empty, 1'b1);
    READ = 1'b1; tick(); READ = 1'b0;
    chk("ovf.empty_read.valid", valid, 1'b0);
    chk("ovf.empty_read.dout", dout, 8'h04);

    // async reset landing in SETTLE with two words stored
    capture(8'hC3, 1); capture(8'h81, 1);
    chk("pre_rst.errcnt", errcnt, 8'd3);
    WRITE = 1'b1; READ = 1'b0; DIN = 8'h77; PIN = 1'b1;
    tick();
    #2 RST = 1'b1;
    #1;
    chk("arst.valid", valid, 1'b0);
    chk("arst.dout", dout, 8'h00);
    chk("arst.pout", pout, 1'b0);
    chk("arst.perr", perr, 1'b0);
    chk("arst.full", full, 1'b0);
    chk("arst.empty", empty, 1'b1);
    chk("arst.errcnt", errcnt, 8'h00);
    chk("arst.ovf", ovf, 1'b0);
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;
    repeat (5) tick();
    WRITE = 1'b0;
    tick();
    chk("arst.no_phantom.empty", empty, 1'b1);
    chk("arst.no_phantom.errcnt", errcnt, 8'h00);
    capture(8'h3C, 0);
    pop_chk("arst.fresh", 8'h3C, 0);

    // 300 bad-parity words, two in / two out, wrapping pointers many times
    for (int k = 0; k < 150; k++) begin
      logic [7:0] d0, d1;
      d0 = 8'(2 * k);
      d1 = 8'(2 * k + 1);
      capture(d0, ~^d0);
      capture(d1, ~^d1);
      pop_chk($sformatf("wrap%0d.a", k), d0, 1);
      pop_chk($sformatf("wrap%0d.b", k), d1, 1);
      if (k == 126) chk("wrap.errcnt254", errcnt, 8'd254);
    end
    chk("wrap.errcnt_sat", errcnt, 8'd255);
    chk("wrap.ovf", ovf, 1'b0);
    chk("wrap.empty", empty, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
